// File: rtl/lc3_io_pkg.sv
// Shared LC-3 I/O definitions: host status codes and keyboard responder FSM states.
package lc3_io_pkg;

  // Status register codes exchanged between host KBSR and device
  localparam logic [15:0] SR_IDLE = 16'h0000;
  localparam logic [15:0] SR_REQ  = 16'h0001;
  localparam logic [15:0] SR_DONE = 16'h0002;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LOAD,
    DONE
  } kbd_state_e;

endpackage

// File: rtl/kbd_fifo.sv
// DEPTH x 8 synchronous FIFO with natural pointer wrap and a separate occupancy count.
// Pushes while full and pops while empty are ignored.
module kbd_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  output logic [7:0]                   pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_ok, pop_ok;

  // Full/empty come from the registered count, so a push while full is refused
  // even if a pop happens in the same cycle.
  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Storage array, written at the write pointer
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/kbd_responder.sv
// Keyboard KBSR/KBDR device-side responder. Buffers key bytes in a FIFO and hands one
// key to the host per request (KBSR_OUT == 1), presenting KBDR a cycle before status 2.
// Optional: define KBD_RESP_TIMEOUT_EN to give up on an empty FIFO after TIMEOUT cycles.
module kbd_responder
  import lc3_io_pkg::*;
#(
  parameter int unsigned DEPTH = 4
`ifdef KBD_RESP_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 1024
`endif
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Key_Valid,
  input  logic [7:0]  i_Key_Data,
  output logic        o_Key_Ready,
  input  logic [15:0] KBSR_OUT,
  output logic [15:0] INPUT_KBDR,
  output logic [15:0] INPUT_KBSR,
  output logic        o_Overflow,
  output logic        o_Timeout
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  kbd_state_e      state_q, state_d;
  logic [15:0]     kbdr_q, kbdr_d;
  logic            overflow_q;
  logic            req;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_data;
  logic [CntW-1:0] fifo_count;
`ifdef KBD_RESP_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            tmo_fire;
  logic            timeout_q;
`endif

  kbd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_Clk),
    .rst_n     (i_Rst_n),
    .push      (i_Key_Valid),
    .push_data (i_Key_Data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign req         = (KBSR_OUT == SR_REQ);
  assign o_Key_Ready = !fifo_full;
  assign o_Overflow  = overflow_q;
  assign INPUT_KBDR  = kbdr_q;
  assign INPUT_KBSR  = (state_q == DONE) ? SR_DONE : SR_IDLE;

  // Next state; the key is popped and latched on the edge entering LOAD so KBDR
  // leads the done status by one full cycle.
  always_comb begin
    state_d  = state_q;
    kbdr_d   = kbdr_q;
    fifo_pop = 1'b0;
`ifdef KBD_RESP_TIMEOUT_EN
    tmo_fire = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (!fifo_empty) begin
            state_d  = LOAD;
            fifo_pop = 1'b1;
            kbdr_d   = {8'h00, fifo_data};
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          state_d  = LOAD;
          fifo_pop = 1'b1;
          kbdr_d   = {8'h00, fifo_data};
`ifdef KBD_RESP_TIMEOUT_EN
        end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
          state_d  = LOAD;
          kbdr_d   = 16'h0000;
          tmo_fire = 1'b1;
`endif
        end
      end
      LOAD: state_d = DONE;
      DONE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, delivered data and sticky overflow
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      kbdr_q     <= 16'h0000;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kbdr_q  <= kbdr_d;
      if (i_Key_Valid && (fifo_count == CntW'(DEPTH))) overflow_q <= 1'b1;
    end
  end

`ifdef KBD_RESP_TIMEOUT_EN
  // Wait counter is held at zero outside WAIT, so it restarts on every entry
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
      else                 tmo_cnt_q <= '0;
      if (tmo_fire) timeout_q <= 1'b1;
    end
  end

  assign o_Timeout = timeout_q;
`else
  assign o_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_responder.sv
// Self-checking bench for kbd_responder: directed handshake cases plus randomized key
// bursts checked against a queue-based model of the key buffer.
module tb_kbd_responder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [7:0]  key_data;
  logic        key_ready;
  logic [15:0] kbsr_out;
  logic [15:0] kbdr;
  logic [15:0] kbsr_in;
  logic        overflow;
  logic        timeout;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Model: bytes accepted by the device and not yet delivered, oldest first
  logic [7:0]  model_q[$];
  logic        model_ovf;
  logic [15:0] last_kbdr;

  always #5 clk = ~clk;

  kbd_responder #(
    .DEPTH (DEPTH)
`ifdef KBD_RESP_TIMEOUT_EN
    , .TIMEOUT (TMO)
`endif
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Key_Valid (key_valid),
    .i_Key_Data  (key_data),
    .o_Key_Ready (key_ready),
    .KBSR_OUT    (kbsr_out),
    .INPUT_KBDR  (kbdr),
    .INPUT_KBSR  (kbsr_in),
    .o_Overflow  (overflow),
    .o_Timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle key strobe; the model accepts it only if the buffer has room
  task automatic push_key(input logic [7:0] k);
    key_valid = 1'b1;
    key_data  = k;
    if (model_q.size() < DEPTH) model_q.push_back(k);
    else                        model_ovf = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // Full host handshake expecting the oldest buffered key
  task automatic request(input string tag);
    logic [7:0] exp;
    bit         seen;
    seen     = 1'b0;
    exp      = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
    kbsr_out = 16'h0001;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (kbsr_in == 16'h0002) seen = 1'b1;
    end
    check($sformatf("%s done", tag), 32'(seen), 32'd1);
    check($sformatf("%s data", tag), 32'(kbdr), {24'h0, exp});
    last_kbdr = {8'h00, exp};
    kbsr_out  = 16'h0002;
    tick();
    check($sformatf("%s release", tag), 32'(kbsr_in), 32'h0);
    kbsr_out = 16'h0000;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int unsigned n;
    int unsigned cyc;

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_data  = 8'h00;
    kbsr_out  = 16'h0000;
    model_ovf = 1'b0;
    last_kbdr = 16'h0000;
    #12;
    check("rst kbdr", 32'(kbdr), 32'h0);
    check("rst kbsr", 32'(kbsr_in), 32'h0);
    check("rst ready", 32'(key_ready), 32'd1);
    check("rst ovf", 32'(overflow), 32'd0);
    check("rst tmo", 32'(timeout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Exact latency: KBDR at +1, status 2 at +2, status clears one cycle after release
    push_key(8'h41);
    void'(model_q.pop_front());
    kbsr_out = 16'h0001;
    tick();
    check("lat kbdr+1", 32'(kbdr), 32'h41);
    check("lat kbsr+1", 32'(kbsr_in), 32'h0);
    tick();
    check("lat kbsr+2", 32'(kbsr_in), 32'h2);
    tick();
    check("lat hold", 32'(kbsr_in), 32'h2);
    kbsr_out = 16'h0002;
    tick();
    check("lat release", 32'(kbsr_in), 32'h0);
    check("lat kbdr kept", 32'(kbdr), 32'h41);
    kbsr_out = 16'h0000;
    tick();

    // Request on an empty buffer waits, then serves a late key
    kbsr_out = 16'h0001;
    repeat (10) tick();
    check("wait kbsr", 32'(kbsr_in), 32'h0);
    push_key(8'h5A);
    request("wait path");

    // Overfill: fifth byte dropped, sticky overflow, in-order delivery of the first four
    for (int i = 0; i < 5; i++) begin
      push_key(8'h31 + 8'(i));
      if (i == 3) begin
        check("fill ready", 32'(key_ready), 32'd0);
        check("fill ovf0", 32'(overflow), 32'd0);
      end
    end
    check("fill ovf1", 32'(overflow), 32'(model_ovf));
    for (int i = 0; i < 4; i++) request($sformatf("fill req%0d", i));
    check("drain ready", 32'(key_ready), 32'd1);

    // Randomized bursts with wrap-around of the pointers
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(DEPTH - model_q.size(), (model_q.size() == 0) ? 1 : 0);
      for (int k = 0; k < int'(n); k++) push_key(8'($urandom));
      if (model_q.size() == DEPTH && $urandom_range(1, 0) == 1) push_key(8'($urandom));
      check($sformatf("rnd ready%0d", it), 32'(key_ready), 32'(model_q.size() < DEPTH));
      check($sformatf("rnd ovf%0d", it), 32'(overflow), 32'(model_ovf));
      request($sformatf("rnd req%0d", it));
    end
    while (model_q.size() > 0) request("rnd drain");

    // Reset while in DONE drops everything at once
    push_key(8'h61);
    push_key(8'h62);
    kbsr_out = 16'h0001;
    seen     = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (kbsr_in == 16'h0002) seen = 1'b1;
    end
    check("mid done", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst kbsr", 32'(kbsr_in), 32'h0);
    check("mid rst kbdr", 32'(kbdr), 32'h0);
    check("mid rst ready", 32'(key_ready), 32'd1);
    check("mid rst ovf", 32'(overflow), 32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    last_kbdr = 16'h0000;
    kbsr_out  = 16'h0000;
    tick();
    rst_n = 1'b1;
    tick();
    kbsr_out = 16'h0001;
    repeat (5) tick();
    check("post rst wait", 32'(kbsr_in), 32'h0);
    push_key(8'h7E);
    request("post rst");

`ifdef KBD_RESP_TIMEOUT_EN
    // Empty-buffer request times out and delivers a null key
    kbsr_out = 16'h0001;
    seen     = 1'b0;
    cyc      = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      cyc++;
      if (kbsr_in == 16'h0002) seen = 1'b1;
    end
    check("tmo done", 32'(seen), 32'd1);
    check("tmo cycles", cyc, TMO + 2);
    check("tmo kbdr", 32'(kbdr), 32'h0);
    check("tmo flag", 32'(timeout), 32'd1);
    kbsr_out = 16'h0000;
    tick();
    check("tmo release", 32'(kbsr_in), 32'h0);
`else
    // Without the timeout the request waits indefinitely; abandoning it returns to idle
    kbsr_out = 16'h0001;
    cyc      = 0;
    repeat (40) begin
      tick();
      if (kbsr_in != 16'h0000) cyc++;
    end
    check("no tmo kbsr", cyc, 32'd0);
    check("no tmo flag", 32'(timeout), 32'd0);
    check("no tmo kbdr", 32'(kbdr), 32'(last_kbdr));
    kbsr_out = 16'h0000;
    tick();
    push_key(8'h23);
    repeat (3) tick();
    check("abandon idle", 32'(kbsr_in), 32'h0);
    request("after abandon");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
